// File: rtl/fpm_pkg.sv
// Shared types and default widths for the floating-point multiplier datapath.
package fpm_pkg;

    localparam int FPM_WIDTH = 16;
    localparam int FPM_POS_W = 4;
    localparam int FPM_EXP_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } fpm_state_e;

    typedef struct packed {
        logic [FPM_WIDTH-1:0] mant;
        logic [FPM_EXP_W-1:0] exp;
        logic                 zero;
        logic                 uflow;
    } fpm_res_t;

endpackage

// File: rtl/fpm_onehot_dec.sv
// Leading-one position back to a one-hot vector; inverse of the priority encoder.
module fpm_onehot_dec
    import fpm_pkg::*;
#(
    parameter int POS_W = FPM_POS_W,
    parameter int WIDTH = FPM_WIDTH
) (
    input  logic [POS_W-1:0] pos_i,
    output logic [WIDTH-1:0] onehot_o
);

    always_comb begin
        onehot_o        = '0;
        onehot_o[pos_i] = 1'b1;
    end

endmodule

// File: rtl/fpm_norm_decoder.sv
// Multi-cycle mantissa normaliser driven by the encoded leading-one position,
// with exponent adjust and zero/underflow flush.
module fpm_norm_decoder
    import fpm_pkg::*;
#(
    parameter int WIDTH = FPM_WIDTH,
    parameter int POS_W = FPM_POS_W,
    parameter int EXP_W = FPM_EXP_W,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mant_in,
    input  logic [POS_W-1:0] pos_in,
    input  logic             nz_in,
    input  logic [EXP_W-1:0] exp_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] mant_out,
    output logic [EXP_W-1:0] exp_out,
    output logic [WIDTH-1:0] onehot_out,
    output logic             zero_out,
    output logic             uflow_out
);

    localparam logic [POS_W-1:0] STEP_W = POS_W'(STEP);

    fpm_state_e       state_q, state_d;
    logic [WIDTH-1:0] mant_q, mant_d;
    logic [WIDTH-1:0] onehot_q, onehot_d, onehot_dec;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [POS_W-1:0] cnt_q, cnt_d, cnt_in, shamt;
    logic             zero_q, zero_d, uflow_q, uflow_d;

    fpm_onehot_dec #(.POS_W(POS_W), .WIDTH(WIDTH)) u_dec (
        .pos_i   (pos_in),
        .onehot_o(onehot_dec)
    );

    assign cnt_in = POS_W'(WIDTH - 1) - pos_in;
    assign shamt  = (cnt_q < STEP_W) ? cnt_q : STEP_W;

    always_comb begin
        state_d  = state_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        onehot_d = onehot_q;
        cnt_d    = cnt_q;
        zero_d   = zero_q;
        uflow_d  = uflow_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mant_d   = mant_in;
                    exp_d    = exp_in;
                    onehot_d = onehot_dec;
                    cnt_d    = cnt_in;
                    zero_d   = 1'b0;
                    uflow_d  = 1'b0;
                    state_d  = DONE;
                    if (!nz_in) begin
                        mant_d   = '0;
                        exp_d    = '0;
                        onehot_d = '0;
                        cnt_d    = '0;
                        zero_d   = 1'b1;
                    end else if (cnt_in != '0 && EXP_W'(cnt_in) >= exp_in) begin
                        // Checked before subtracting so the exponent never wraps.
                        mant_d  = '0;
                        exp_d   = '0;
                        cnt_d   = '0;
                        uflow_d = 1'b1;
                    end else if (cnt_in != '0) begin
                        exp_d   = exp_in - EXP_W'(cnt_in);
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                mant_d = mant_q << shamt;
                cnt_d  = cnt_q - shamt;
                if (cnt_q == shamt) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mant_q   <= '0;
            exp_q    <= '0;
            onehot_q <= '0;
            cnt_q    <= '0;
            zero_q   <= 1'b0;
            uflow_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            onehot_q <= onehot_d;
            cnt_q    <= cnt_d;
            zero_q   <= zero_d;
            uflow_q  <= uflow_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign mant_out   = mant_q;
    assign exp_out    = exp_q;
    assign onehot_out = onehot_q;
    assign zero_out   = zero_q;
    assign uflow_out  = uflow_q;

endmodule
